// File: rtl/data_mem_responder.sv
// data_mem_responder: MEM-stage data-memory responder. Accepts one load/store at a
// time, inserts WAIT_STATES cycles, then completes in a single RESP cycle. Backs a
// word-addressed RAM with byte-enable writes plus one memory-mapped toggle register.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] LED_ADDR    = 32'h34
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        stall,
    output logic [31:0] toggle_value
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    // Counter preload for the WAIT state; unused when there are no wait states.
    localparam logic [2:0] WAIT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] toggle_q, toggle_d;

    logic [31:0]      mem [DEPTH_WORDS];
    logic [31:0]      ram_rd_q;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;

    logic accept;
    logic in_resp;
    logic misaligned;
    logic hit_led;
    logic hit_ram;
    logic access_err;
    logic ram_we;

    assign accept  = req_valid && (state_q == ST_IDLE);
    assign in_resp = (state_q == ST_RESP);

    // State register and all control/response flops; async reset aborts any request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            addr_q      <= 32'd0;
            we_q        <= 1'b0;
            wdata_q     <= 32'd0;
            be_q        <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            toggle_q    <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            toggle_q    <= toggle_d;
        end
    end

    // Next-state logic: IDLE -> WAIT (or straight to RESP) -> RESP -> IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (req_valid) state_d = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (cnt_q == 3'd0) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs: ready only in IDLE; stall is combinational on req_valid there.
    always_comb begin
        req_ready = 1'b0;
        stall     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                stall     = req_valid;
            end
            ST_WAIT: stall = 1'b1;
            default: ;
        endcase
    end

    // Latch the request on accept and count down the wait states.
    always_comb begin
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        cnt_d   = cnt_q;
        if (accept) begin
            addr_d  = req_addr;
            we_d    = req_we;
            wdata_d = req_wdata;
            be_d    = req_be;
            cnt_d   = WAIT_INIT;
        end else if ((state_q == ST_WAIT) && (cnt_q != 3'd0)) begin
            cnt_d = cnt_q - 3'd1;
        end
    end

    // Address decode on the latched address: alignment, then LED, then RAM range.
    always_comb begin
        misaligned = (addr_q[1:0] != 2'b00);
        hit_led    = !misaligned && (addr_q == LED_ADDR);
        hit_ram    = !misaligned && !hit_led && (addr_q[31:IDX_W+2] == '0);
        access_err = !hit_led && !hit_ram;
        ram_we     = in_resp && we_q && hit_ram;
    end

    // Response and toggle-register updates, all taking effect at the end of RESP.
    always_comb begin
        rsp_valid_d = in_resp;
        rsp_err_d   = in_resp && access_err;
        rsp_rdata_d = rsp_rdata_q;
        toggle_d    = toggle_q;
        if (in_resp) begin
            if (access_err) begin
                rsp_rdata_d = 32'd0;
            end else if (!we_q) begin
                rsp_rdata_d = hit_led ? toggle_q : ram_rd_q;
            end else if (hit_led) begin
                for (int i = 0; i < 4; i++) begin
                    if (be_q[i]) toggle_d[8*i +: 8] = wdata_q[8*i +: 8];
                end
            end
        end
    end

    // RAM read index follows the live request in IDLE so zero-wait loads have data in RESP.
    assign rd_idx = (state_q == ST_IDLE) ? req_addr[IDX_W+1:2] : addr_q[IDX_W+1:2];
    assign wr_idx = addr_q[IDX_W+1:2];

    // Block RAM: byte-enable write at the end of RESP, registered read every cycle.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) mem[wr_idx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
        ram_rd_q <= mem[rd_idx];
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_err      = rsp_err_q;
    assign toggle_value = toggle_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: table-driven scoreboard bench. Instance A runs with one wait
// state; instance B runs with zero wait states for the back-to-back throughput case.
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Instance A (WAIT_STATES=1)
    logic        a_req_valid, a_req_ready, a_req_we;
    logic [31:0] a_req_addr, a_req_wdata;
    logic [3:0]  a_req_be;
    logic        a_rsp_valid, a_rsp_err, a_stall;
    logic [31:0] a_rsp_rdata, a_toggle_value;

    // Instance B (WAIT_STATES=0)
    logic        b_req_valid, b_req_ready, b_req_we;
    logic [31:0] b_req_addr, b_req_wdata;
    logic [3:0]  b_req_be;
    logic        b_rsp_valid, b_rsp_err, b_stall;
    logic [31:0] b_rsp_rdata, b_toggle_value;

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1), .LED_ADDR(32'h34)) u_dut_a (
        .clk(clk), .reset(reset),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
        .stall(a_stall), .toggle_value(a_toggle_value)
    );

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0), .LED_ADDR(32'h34)) u_dut_b (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .stall(b_stall), .toggle_value(b_toggle_value)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [31:0] exp_toggle;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] toggle;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor for instance A: every response pops one expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (a_rsp_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 rdata=%08h expected no response",
                             a_rsp_rdata);
                end else begin
                    mon_e = sb_q.pop_front();
                    $display("A rsp: rdata=%08h err=%0b toggle=%08h (exp %08h %0b %08h)",
                             a_rsp_rdata, a_rsp_err, a_toggle_value,
                             mon_e.rdata, mon_e.err, mon_e.toggle);
                    check("rsp_rdata", a_rsp_rdata, mon_e.rdata);
                    check("rsp_err", {31'd0, a_rsp_err}, {31'd0, mon_e.err});
                    check("toggle_value", a_toggle_value, mon_e.toggle);
                end
            end
        end
    end

    // One request on instance A, entered and left at posedge+1 in IDLE.
    task automatic do_req(input vec_t v);
        int   cyc;
        int   n_stall;
        exp_t e;
        e.rdata  = v.exp_rdata;
        e.err    = v.exp_err;
        e.toggle = v.exp_toggle;
        sb_q.push_back(e);
        a_req_valid = 1'b1;
        a_req_we    = v.we;
        a_req_addr  = v.addr;
        a_req_wdata = v.wdata;
        a_req_be    = v.be;
        #1;
        check("req_ready_idle", {31'd0, a_req_ready}, 32'd1);
        n_stall = (a_stall === 1'b1) ? 1 : 0;
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        cyc = 0;
        while (a_rsp_valid !== 1'b1 && cyc < 20) begin
            if (a_stall === 1'b1) n_stall++;
            @(posedge clk); #1;
            cyc++;
        end
        check("rsp_latency", cyc, 32'd2);
        check("stall_cycles", n_stall, 32'd2);
        @(posedge clk); #1;
        check("rsp_pulse_width", {31'd0, a_rsp_valid}, 32'd0);
    endtask

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs[26];
        vec_t        v;
        logic        b_we_t[4];
        logic [31:0] b_addr_t[4];
        logic [31:0] b_wdata_t[4];
        logic [31:0] b_exp_t[4];

        reset = 1'b1;
        a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_req_be = '0;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_be = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_req_ready", {31'd0, a_req_ready}, 32'd1);
        check("reset_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
        check("reset_rsp_rdata", a_rsp_rdata, 32'd0);
        check("reset_rsp_err", {31'd0, a_rsp_err}, 32'd0);
        check("reset_toggle", a_toggle_value, 32'd0);
        check("reset_stall", {31'd0, a_stall}, 32'd0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;

        //            we    addr            wdata          be     exp_rdata      err   toggle
        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 32'h0000_0000, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 32'h0000_0020, 32'h11223344, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 32'h0000_0020, 32'hAABBCCDD, 4'h5, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 32'h0000_0020, 32'h0,        4'h0, 32'h11BB33DD, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 32'h0000_0030, 32'hCAFEF00D, 4'hF, 32'h11BB33DD, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 32'h0000_0038, 32'h0BADC0DE, 4'hF, 32'h11BB33DD, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 32'h0000_0034, 32'h00000001, 4'hF, 32'h11BB33DD, 1'b0, 32'h1};
        vecs[8]  = '{1'b0, 32'h0000_0034, 32'h0,        4'h0, 32'h00000001, 1'b0, 32'h1};
        vecs[9]  = '{1'b0, 32'h0000_0030, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0, 32'h1};
        vecs[10] = '{1'b0, 32'h0000_0038, 32'h0,        4'h0, 32'h0BADC0DE, 1'b0, 32'h1};
        vecs[11] = '{1'b1, 32'h0000_0034, 32'hA5A5FF00, 4'h2, 32'h0BADC0DE, 1'b0, 32'hFF01};
        vecs[12] = '{1'b0, 32'h0000_0034, 32'h0,        4'h0, 32'h0000FF01, 1'b0, 32'hFF01};
        vecs[13] = '{1'b1, 32'h0000_0000, 32'h12345678, 4'hF, 32'h0000FF01, 1'b0, 32'hFF01};
        vecs[14] = '{1'b0, 32'h0000_0022, 32'h0,        4'h0, 32'h00000000, 1'b1, 32'hFF01};
        vecs[15] = '{1'b1, 32'h0000_1000, 32'hFFFFFFFF, 4'hF, 32'h00000000, 1'b1, 32'hFF01};
        vecs[16] = '{1'b1, 32'h0000_0002, 32'hFFFFFFFF, 4'hF, 32'h00000000, 1'b1, 32'hFF01};
        vecs[17] = '{1'b0, 32'h0000_0000, 32'h0,        4'h0, 32'h12345678, 1'b0, 32'hFF01};
        vecs[18] = '{1'b1, 32'h0000_0000, 32'hFFFFFFFF, 4'h0, 32'h12345678, 1'b0, 32'hFF01};
        vecs[19] = '{1'b0, 32'h0000_0000, 32'h0,        4'h0, 32'h12345678, 1'b0, 32'hFF01};
        vecs[20] = '{1'b1, 32'h0000_0FFC, 32'h76543210, 4'hF, 32'h12345678, 1'b0, 32'hFF01};
        vecs[21] = '{1'b0, 32'h0000_0FFC, 32'h0,        4'h0, 32'h76543210, 1'b0, 32'hFF01};
        vecs[22] = '{1'b0, 32'h8000_0000, 32'h0,        4'h0, 32'h00000000, 1'b1, 32'hFF01};
        vecs[23] = '{1'b1, 32'h0000_0010, 32'h99000000, 4'h8, 32'h00000000, 1'b0, 32'hFF01};
        vecs[24] = '{1'b0, 32'h0000_0010, 32'h0,        4'h0, 32'h99ADBEEF, 1'b0, 32'hFF01};
        vecs[25] = '{1'b1, 32'h0000_0040, 32'h600DF00D, 4'hF, 32'h99ADBEEF, 1'b0, 32'hFF01};

        for (int i = 0; i < 26; i++) begin
            $display("A req %0d: we=%0b addr=%08h wdata=%08h be=%h", i,
                     vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be);
            do_req(vecs[i]);
        end

        // Reset while a store is waiting: it must be abandoned without writing.
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h40;
        a_req_wdata = 32'h55; a_req_be = 4'hF;
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        check("wait_stall", {31'd0, a_stall}, 32'd1);
        reset = 1'b1;
        #1;
        check("abort_req_ready", {31'd0, a_req_ready}, 32'd1);
        check("abort_stall", {31'd0, a_stall}, 32'd0);
        check("abort_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
        check("abort_toggle", a_toggle_value, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        check("release_req_ready", {31'd0, a_req_ready}, 32'd1);
        check("release_rsp_rdata", a_rsp_rdata, 32'd0);
        v = '{1'b0, 32'h40, 32'h0, 4'h0, 32'h600DF00D, 1'b0, 32'h0};
        $display("A req abort-check: load addr=00000040");
        do_req(v);

        // Zero wait states: req_valid held high, one accept every two cycles.
        b_we_t    = '{1'b1, 1'b1, 1'b0, 1'b0};
        b_addr_t  = '{32'h8, 32'hC, 32'h8, 32'hC};
        b_wdata_t = '{32'h13572468, 32'h2468ACE0, 32'h0, 32'h0};
        b_exp_t   = '{32'h0, 32'h0, 32'h13572468, 32'h2468ACE0};
        for (int i = 0; i < 4; i++) begin
            b_req_valid = 1'b1;
            b_req_we    = b_we_t[i];
            b_req_addr  = b_addr_t[i];
            b_req_wdata = b_wdata_t[i];
            b_req_be    = 4'hF;
            #1;
            check("b_ready_idle", {31'd0, b_req_ready}, 32'd1);
            check("b_stall_idle", {31'd0, b_stall}, 32'd1);
            @(posedge clk); #1;
            check("b_resp_state", {29'd0, b_req_ready, b_rsp_valid, b_stall}, 32'd0);
            @(posedge clk); #1;
            $display("B req %0d: we=%0b addr=%08h rsp_valid=%0b rdata=%08h (exp %08h)",
                     i, b_we_t[i], b_addr_t[i], b_rsp_valid, b_rsp_rdata, b_exp_t[i]);
            check("b_rsp_valid", {31'd0, b_rsp_valid}, 32'd1);
            check("b_rsp_rdata", b_rsp_rdata, b_exp_t[i]);
            check("b_rsp_err", {31'd0, b_rsp_err}, 32'd0);
        end
        b_req_valid = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
